// File: rtl/mips_monitor_pkg.sv
// Shared types and constants for the MIPS run monitor and its optional PC history log.
package mips_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } monitor_state_t;

  typedef enum logic [2:0] {
    FC_NONE             = 3'd0,
    FC_V0_MISMATCH      = 3'd1,
    FC_TIMEOUT          = 3'd2,
    FC_STALL            = 3'd3,
    FC_DRAIN_TIMEOUT    = 3'd4,
    FC_EARLY_INACTIVE   = 3'd5,
    FC_MISALIGNED_STORE = 3'd6
  } fail_code_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam int          HIST_DEPTH   = 8;
  localparam int          HIST_AW      = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mips_pc_history.sv
// Eight-deep ring of recently fetched PCs; index 0 reads the newest entry combinationally.
module mips_pc_history
  import mips_monitor_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [31:0]          wr_pc,
  input  logic [HIST_AW-1:0]   rd_index,
  output logic [31:0]          rd_pc
);

  logic [31:0]        ring_q [HIST_DEPTH];
  logic [31:0]        ring_d [HIST_DEPTH];
  logic [HIST_AW-1:0] wr_ptr_q, wr_ptr_d;

  always_comb begin
    ring_d   = ring_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      ring_d[wr_ptr_q] = wr_pc;
      wr_ptr_d         = wr_ptr_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) ring_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      ring_q   <= ring_d;
    end
  end

  // wr_ptr points at the next free slot, so the newest entry sits one behind it.
  always_comb rd_pc = ring_q[wr_ptr_q - 3'd1 - rd_index];

endmodule

// File: rtl/mips_cpu_run_monitor.sv
// Observer beside mips_cpu_harvard: detects program end and reports done/pass/fail plus counters.
// Optional MIPS_RUN_MONITOR_HISTORY_EN adds an 8-entry fetch-address history (hist_index/hist_pc).
module mips_cpu_run_monitor
  import mips_monitor_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR   = 32'h0000_0000,
  parameter int unsigned MAX_CYCLES  = 1000,
  parameter int unsigned STALL_LIMIT = 16,
  parameter int unsigned DRAIN_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        active,
  input  logic [31:0] instr_address,
  input  logic [31:0] register_v0,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic        check_v0_en,
  input  logic [31:0] expected_v0,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [2:0]  fail_code,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
  output logic [15:0] store_count
`ifdef MIPS_RUN_MONITOR_HISTORY_EN
  ,
  input  logic [2:0]  hist_index,
  output logic [31:0] hist_pc
`endif
);

  monitor_state_t state_q, state_d;
  fail_code_t     fail_code_q, fail_code_d, err;
  logic           done_q, done_d;
  logic [31:0]    prev_addr_q, prev_addr_d;
  logic [31:0]    cycle_q, cycle_d;
  logic [31:0]    instr_q, instr_d;
  logic [31:0]    stall_q, stall_d;
  logic [31:0]    drain_q, drain_d;
  logic [15:0]    store_q, store_d;

  logic           addr_chg, bad_store, at_halt, v0_bad, in_exec;
  logic [31:0]    cyc_n, stall_n, drain_n;

  always_comb begin
    addr_chg  = (instr_address != prev_addr_q);
    bad_store = data_write && ((data_address & 32'h0000_0003) != 32'h0);
    at_halt   = (instr_address == HALT_ADDR);
    v0_bad    = check_v0_en && (register_v0 != expected_v0);
    in_exec   = (state_q == RUN) || (state_q == DRAIN);
    cyc_n     = cycle_q + 32'd1;
    stall_n   = addr_chg ? 32'd0 : stall_q + 32'd1;
    drain_n   = drain_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Error priority within one cycle: bad store, then halt fetch, then the RUN-only checks.
  always_comb begin
    state_d = state_q;
    err     = FC_NONE;
    if (clk_enable) begin
      case (state_q)
        IDLE: if (active) state_d = RUN;
        RUN: begin
          if (bad_store)                  err     = FC_MISALIGNED_STORE;
          else if (at_halt)               state_d = DRAIN;
          else if (!active)               err     = FC_EARLY_INACTIVE;
          else if (stall_n >= STALL_LIMIT) err    = FC_STALL;
          else if (cyc_n >= MAX_CYCLES)   err     = FC_TIMEOUT;
        end
        DRAIN: begin
          if (bad_store) err = FC_MISALIGNED_STORE;
          else if (!active) begin
            state_d = DONE;
            if (v0_bad) err = FC_V0_MISMATCH;
          end
          else if (drain_n >= DRAIN_LIMIT) err = FC_DRAIN_TIMEOUT;
        end
        default: state_d = state_q;
      endcase
      if (err != FC_NONE) state_d = DONE;
    end
  end

  always_comb begin
    prev_addr_d = prev_addr_q;
    cycle_d     = cycle_q;
    instr_d     = instr_q;
    stall_d     = stall_q;
    drain_d     = drain_q;
    store_d     = store_q;
    done_d      = done_q;
    fail_code_d = fail_code_q;
    if (clk_enable && (state_q != DONE)) begin
      prev_addr_d = instr_address;
      if (in_exec) begin
        cycle_d = cyc_n;
        if (data_write) store_d = sat_inc16(store_q);
      end
      if (state_q == RUN) begin
        stall_d = stall_n;
        if (addr_chg) instr_d = instr_q + 32'd1;
      end
      if (state_q == DRAIN) drain_d = drain_n;
      if (state_d == DONE) begin
        done_d      = 1'b1;
        fail_code_d = err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_addr_q <= '0;
      cycle_q     <= '0;
      instr_q     <= '0;
      stall_q     <= '0;
      drain_q     <= '0;
      store_q     <= '0;
      done_q      <= 1'b0;
      fail_code_q <= FC_NONE;
    end else begin
      prev_addr_q <= prev_addr_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
      stall_q     <= stall_d;
      drain_q     <= drain_d;
      store_q     <= store_d;
      done_q      <= done_d;
      fail_code_q <= fail_code_d;
    end
  end

  always_comb begin
    done        = done_q;
    pass        = done_q && (fail_code_q == FC_NONE);
    fail        = done_q && (fail_code_q != FC_NONE);
    fail_code   = fail_code_q;
    cycle_count = cycle_q;
    instr_count = instr_q;
    store_count = store_q;
  end

`ifdef MIPS_RUN_MONITOR_HISTORY_EN
  logic hist_wr;
  assign hist_wr = clk_enable && in_exec && addr_chg;

  mips_pc_history u_hist (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en    (hist_wr),
    .wr_pc    (instr_address),
    .rd_index (hist_index),
    .rd_pc    (hist_pc)
  );
`endif

endmodule

// File: tb/tb_mips_cpu_run_monitor.sv
// Bench for mips_cpu_run_monitor: directed programs with literal verdicts plus randomized runs vs a model.
module tb_mips_cpu_run_monitor;

  localparam logic [31:0] RV     = 32'hBFC0_0000;
  localparam logic [31:0] HALT   = 32'h0000_0000;
  localparam int          MAXC   = 50;
  localparam int          STALLL = 16;
  localparam int          DRAINL = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b0;
  logic        active = 1'b0;
  logic [31:0] instr_address = '0;
  logic [31:0] register_v0 = '0;
  logic        data_write = 1'b0;
  logic [31:0] data_address = '0;
  logic        check_v0_en = 1'b0;
  logic [31:0] expected_v0 = '0;
  logic        done, pass, fail;
  logic [2:0]  fail_code;
  logic [31:0] cycle_count, instr_count;
  logic [15:0] store_count;
`ifdef MIPS_RUN_MONITOR_HISTORY_EN
  logic [2:0]  hist_index = '0;
  logic [31:0] hist_pc;
`endif

  always #5 clk = ~clk;

  mips_cpu_run_monitor #(
    .HALT_ADDR   (HALT),
    .MAX_CYCLES  (MAXC),
    .STALL_LIMIT (STALLL),
    .DRAIN_LIMIT (DRAINL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .active        (active),
    .instr_address (instr_address),
    .register_v0   (register_v0),
    .data_write    (data_write),
    .data_address  (data_address),
    .check_v0_en   (check_v0_en),
    .expected_v0   (expected_v0),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .fail_code     (fail_code),
    .cycle_count   (cycle_count),
    .instr_count   (instr_count),
    .store_count   (store_count)
`ifdef MIPS_RUN_MONITOR_HISTORY_EN
    ,
    .hist_index    (hist_index),
    .hist_pc       (hist_pc)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: a program has "started", may have "halted" (waiting for active to drop), and is "finished".
  bit          m_started, m_halted, m_finished;
  int          m_cyc, m_instr, m_store, m_same, m_drain;
  logic [31:0] m_last;
  logic [2:0]  m_code;

  always @(posedge clk or negedge reset) begin : model
    int  code;
    bit  stop;
    bit  bad;
    if (!reset) begin
      m_started = 0; m_halted = 0; m_finished = 0;
      m_cyc = 0; m_instr = 0; m_store = 0; m_same = 0; m_drain = 0;
      m_last = '0; m_code = '0;
    end else if (clk_enable && !m_finished) begin
      code = 0;
      stop = 0;
      bad  = data_write && (data_address[1:0] != 2'b00);
      if (!m_started) begin
        if (active) m_started = 1;
      end else begin
        m_cyc++;
        if (data_write && m_store < 65535) m_store++;
        if (!m_halted) begin
          if (instr_address != m_last) begin m_instr++; m_same = 0; end
          else m_same++;
          if (bad)                          code = 6;
          else if (instr_address == HALT)   m_halted = 1;
          else if (!active)                 code = 5;
          else if (m_same >= STALLL)        code = 3;
          else if (m_cyc >= MAXC)           code = 2;
          stop = (code != 0);
        end else begin
          m_drain++;
          if (bad) begin code = 6; stop = 1; end
          else if (!active) begin
            stop = 1;
            if (check_v0_en && register_v0 != expected_v0) code = 1;
          end
          else if (m_drain >= DRAINL) begin code = 4; stop = 1; end
        end
        if (stop) begin m_finished = 1; m_code = code[2:0]; end
      end
      m_last = instr_address;
    end
  end

  always @(negedge clk) begin : compare
    logic [2:0] e_code;
    if (reset) begin
      e_code = m_finished ? m_code : 3'd0;
      vectors++;
      if (done !== m_finished || pass !== (m_finished && e_code == 0) ||
          fail !== (m_finished && e_code != 0) || fail_code !== e_code ||
          cycle_count !== m_cyc || instr_count !== m_instr || store_count !== m_store[15:0]) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t got d/p/f/code=%b%b%b/%0d cyc=%0d ins=%0d st=%0d want %b/%0d cyc=%0d ins=%0d st=%0d",
                 $time, done, pass, fail, fail_code, cycle_count, instr_count, store_count,
                 m_finished, e_code, m_cyc, m_instr, m_store);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input bit en, input bit act, input logic [31:0] pc,
                     input bit wr = 1'b0, input logic [31:0] da = 32'h0);
    clk_enable = en; active = act; instr_address = pc; data_write = wr; data_address = da;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 32'h0);
    reset = 1'b1;
  endtask

  task automatic prog1(input logic [31:0] exp_v0);
    register_v0 = 32'd1; expected_v0 = exp_v0; check_v0_en = 1'b1;
    cyc(1, 1, RV); cyc(1, 1, RV + 4); cyc(1, 1, RV + 8); cyc(1, 1, HALT); cyc(1, 0, HALT);
  endtask

  initial begin
    logic [31:0] pc, da;
    int          len;
    bit          stuck, en, wr;

    do_reset();
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_code", {29'b0, fail_code}, 32'd0);
    chk("reset_cycles", cycle_count, 32'd0);

    prog1(32'd1);
    chk("p1_done", {31'b0, done}, 32'd1);
    chk("p1_pass", {31'b0, pass}, 32'd1);
    chk("p1_code", {29'b0, fail_code}, 32'd0);
    chk("p1_cycles", cycle_count, 32'd4);
    chk("p1_instrs", instr_count, 32'd3);
    chk("p1_stores", {16'b0, store_count}, 32'd0);

    do_reset();
    prog1(32'd2);
    chk("p2_fail", {31'b0, fail}, 32'd1);
    chk("p2_code", {29'b0, fail_code}, 32'd1);

    do_reset();
    check_v0_en = 1'b0;
    for (int i = 0; i < 17; i++) cyc(1, 1, RV);
    chk("stall_code", {29'b0, fail_code}, 32'd3);
    chk("stall_cycles", cycle_count, 32'd16);
    for (int i = 0; i < 3; i++) cyc(1, 1, RV, 1'b1, 32'h100);
    chk("done_frozen_cycles", cycle_count, 32'd16);
    chk("done_frozen_stores", {16'b0, store_count}, 32'd0);

    do_reset();
    cyc(1, 1, RV);
    for (int i = 0; i < 60; i++) cyc(1, 1, (i % 2 == 0) ? RV + 4 : RV);
    chk("timeout_code", {29'b0, fail_code}, 32'd2);
    chk("timeout_cycles", cycle_count, 32'd50);

    do_reset();
    cyc(1, 1, RV); cyc(1, 1, RV + 4, 1'b1, 32'h0000_0402);
    chk("misaligned_code", {29'b0, fail_code}, 32'd6);

    do_reset();
    cyc(1, 1, RV);
    cyc(1, 1, RV + 4,  1'b1, 32'h100);
    cyc(1, 1, RV + 8,  1'b1, 32'h104);
    cyc(1, 1, RV + 12, 1'b1, 32'h108);
    cyc(1, 1, HALT); cyc(1, 0, HALT);
    chk("stores_pass", {31'b0, pass}, 32'd1);
    chk("stores_count", {16'b0, store_count}, 32'd3);

    do_reset();
    cyc(1, 1, RV); cyc(1, 1, RV + 4); cyc(1, 1, RV + 8);
    reset = 1'b0;
    #1;
    chk("midreset_cycles", cycle_count, 32'd0);
    chk("midreset_instrs", instr_count, 32'd0);
    chk("midreset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    prog1(32'd1);
    chk("rerun_pass", {31'b0, pass}, 32'd1);
`ifdef MIPS_RUN_MONITOR_HISTORY_EN
    hist_index = 3'd0; #1;
    chk("hist0", hist_pc, 32'h0000_0000);
    hist_index = 3'd1; #1;
    chk("hist1", hist_pc, 32'hBFC0_0008);
`endif

    do_reset();
    check_v0_en = 1'b0;
    cyc(1, 1, RV); cyc(1, 1, RV + 4);
    for (int i = 0; i < 20; i++) cyc(0, 1, RV + 4);
    chk("freeze_cycles", cycle_count, 32'd1);
    chk("freeze_no_stall", {31'b0, done}, 32'd0);
    cyc(1, 1, RV + 8); cyc(1, 1, HALT); cyc(1, 0, HALT);
    chk("freeze_pass", {31'b0, pass}, 32'd1);

    for (int p = 0; p < 40; p++) begin
      do_reset();
      check_v0_en = 1'($urandom_range(0, 1));
      register_v0 = $urandom_range(0, 3);
      expected_v0 = $urandom_range(0, 3);
      stuck = ($urandom_range(0, 3) == 0);
      pc = RV;
      for (int i = 0; i < $urandom_range(0, 3); i++) cyc(1, 0, pc);
      cyc(1, 1, pc);
      len = $urandom_range(1, 60);
      for (int i = 0; i < len; i++) begin
        en = ($urandom_range(0, 7) != 0);
        if (stuck ? ($urandom_range(0, 24) == 0) : ($urandom_range(0, 4) != 0)) pc = pc + 4;
        wr = ($urandom_range(0, 5) == 0);
        da = $urandom() & 32'h0000_0FFC;
        if ($urandom_range(0, 30) == 0) da = da | 32'h1;
        if ($urandom_range(0, 60) == 0) begin
          reset = 1'b0;
          cyc(en, 1, pc);
          reset = 1'b1;
        end else begin
          cyc(en, ($urandom_range(0, 79) != 0), pc, wr, da);
        end
      end
      cyc(1, 1, HALT);
      for (int k = 0; k < $urandom_range(0, 11); k++)
        cyc(($urandom_range(0, 5) != 0), 1, HALT, ($urandom_range(0, 4) == 0), 32'h200);
      for (int k = 0; k < 3; k++) cyc(1, 0, HALT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
